eject_port_arbiter: RTL

- Packet-granular round-robin arbiter that shares the single local ejection path (flit, recieved, hand_shake) of a NoC node between 4 router output requesters (N, E, S, W).
- Sits between the router crossbar outputs and the node's packet receiver/CPU sink.
- Locks a grant from head flit to tail flit, so packets are never interleaved at the sink.

---
 rtl/eject_port_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/eject_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : eject_port_arbiter
// Description : Packet-granular round-robin arbiter sharing a NoC node's single
//               ejection path among the N/E/S/W router outputs. A grant is held
//               from head to tail so packets never interleave at the sink.
//               Optional per-port packet counters and stall flag are enabled
//               by defining EJECT_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module eject_port_arbiter #(
  parameter int LL = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      req,
  input  logic [4*LL-1:0] flit_in,
  output logic [3:0]      ack,
  output logic            recieved,
  output logic [LL-1:0]   flit,
  input  logic            hand_shake,
  output logic [3:0]      grant,
  output logic            busy
`ifdef EJECT_ARB_STATS_EN
  ,
  output logic [63:0]     pkt_cnt,
  output logic            stall
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_LOCK = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_rr_ptr, w_rr_ptr_nxt;
  logic [1:0]      r_owner, w_owner_nxt;
  logic [3:0]      r_grant, w_grant_nxt;
  logic [3:0]      r_ack, w_ack_nxt;
  logic            r_recieved, w_recieved_nxt;
  logic [LL-1:0]   r_flit, w_flit_nxt;

  logic [LL-1:0]   w_req_flit [4];
  logic [3:0]      w_elig;
  logic [7:0]      w_rot_dbl;
  logic [1:0]      w_win_idx;
  logic            w_win_valid;
  logic            w_release;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_unpack
      assign w_req_flit[gi] = flit_in[gi*LL +: LL];
    end
  endgenerate

  // A requester still shows its consumed flit during its ack cycle; mask it.
  assign w_elig      = req & ~r_ack;
  assign w_win_valid = |w_elig;
  // Type 10 (tail) and 11 (single) both have the MSB set and end the packet.
  assign w_release   = r_flit[LL-1];

  // Rotate so bit 0 is the pointer position; lowest set bit wins.
  always_comb begin
    w_rot_dbl = {w_elig, w_elig} >> r_rr_ptr;
    w_win_idx = r_rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (w_rot_dbl[k]) w_win_idx = r_rr_ptr + 2'(k);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= 2'd0;
      r_owner    <= 2'd0;
      r_grant    <= 4'd0;
      r_ack      <= 4'd0;
      r_recieved <= 1'b0;
      r_flit     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_grant    <= w_grant_nxt;
      r_ack      <= w_ack_nxt;
      r_recieved <= w_recieved_nxt;
      r_flit     <= w_flit_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_owner_nxt    = r_owner;
    w_grant_nxt    = r_grant;
    w_ack_nxt      = 4'd0;
    w_recieved_nxt = r_recieved;
    w_flit_nxt     = r_flit;
    case (r_state)
      S_IDLE: begin
        if (w_win_valid) begin
          w_owner_nxt    = w_win_idx;
          w_grant_nxt    = 4'b0001 << w_win_idx;
          w_flit_nxt     = w_req_flit[w_win_idx];
          w_recieved_nxt = 1'b1;
          w_state_nxt    = S_SEND;
        end
      end
      S_SEND: begin
        if (hand_shake) begin
          w_recieved_nxt = 1'b0;
          w_ack_nxt      = r_grant;
          if (w_release) begin
            w_rr_ptr_nxt = r_owner + 2'd1;
            w_grant_nxt  = 4'd0;
            w_state_nxt  = S_IDLE;
          end else begin
            w_state_nxt  = S_LOCK;
          end
        end
      end
      S_LOCK: begin
        if (w_elig[r_owner]) begin
          w_flit_nxt     = w_req_flit[r_owner];
          w_recieved_nxt = 1'b1;
          w_state_nxt    = S_SEND;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = 4'd0;
      end
    endcase
  end

  assign ack      = r_ack;
  assign recieved = r_recieved;
  assign flit     = r_flit;
  assign grant    = r_grant;
  assign busy     = (r_state != S_IDLE);

`ifdef EJECT_ARB_STATS_EN
  logic w_pkt_done;
  assign w_pkt_done = (r_state == S_SEND) && hand_shake && w_release;
  assign stall      = (r_state == S_SEND) && !hand_shake;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_stats
      logic [15:0] r_pkt_cnt;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_pkt_cnt <= 16'd0;
        end else if (w_pkt_done && (r_owner == 2'(gi))) begin
          r_pkt_cnt <= r_pkt_cnt + 16'd1;
        end
      end
      assign pkt_cnt[gi*16 +: 16] = r_pkt_cnt;
    end
  endgenerate
`endif

endmodule
`default_nettype wire
